// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the core-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } bridge_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_bus.sv
// APB3 bus bundle shared between the bridge and the peripheral interconnect.
interface APB_BUS #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);

  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [APB_DATA_WIDTH-1:0] PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [APB_DATA_WIDTH-1:0] PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport Master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport Slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter; expired flags the last tolerated ACCESS cycle without PREADY.
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_bypass
      assign expired = 1'b0;
    end else begin : g_count
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt_r;

      // Count stalled ACCESS cycles, holding at MAX instead of wrapping.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_r <= '0;
        end else if (clear) begin
          cnt_r <= '0;
        end else if (enable && (cnt_r != MAX)) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end

      // Fires during the TIMEOUT_CYCLES-th stalled cycle so the abort lands right after it.
      assign expired = enable && (cnt_r >= LAST);
    end
  endgenerate

endmodule

// File: rtl/mem2apb_bridge.sv
// Converts core req/gnt/rvalid data requests into single APB3 transfers,
// with a wait-state timeout guarding against hung peripherals.
module mem2apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  input  logic [APB_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  APB_BUS.Master                      apb_master
);

  bridge_state_e state_r, next_state_s;

  logic [APB_ADDR_WIDTH-1:0] paddr_r;
  logic [APB_DATA_WIDTH-1:0] pwdata_r;
  logic                      pwrite_r;
  logic                      psel_r;
  logic                      penable_r;
  logic                      rvalid_r;
  logic [APB_DATA_WIDTH-1:0] rdata_r;
  logic                      err_r;

  logic gnt_s;
  logic load_s;
  logic done_s;
  logic abort_s;
  logic cnt_clear_s;
  logic cnt_en_s;
  logic cnt_expired_s;

  // APB3 has no strobes and PADDR is word aligned, so these bits are deliberately dropped.
  logic unused_s;
  assign unused_s = ^{data_be_i, data_addr_i[1:0]};

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .expired(cnt_expired_s)
  );

  // Next-state and per-state control decode; PREADY takes priority over expiry.
  always_comb begin
    next_state_s = state_r;
    gnt_s        = 1'b0;
    load_s       = 1'b0;
    done_s       = 1'b0;
    abort_s      = 1'b0;
    cnt_clear_s  = 1'b0;
    cnt_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        gnt_s = data_req_i;
        if (data_req_i) begin
          load_s       = 1'b1;
          next_state_s = SETUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        cnt_clear_s  = 1'b1;
        next_state_s = ACCESS;
      end
      ACCESS: begin
        cnt_en_s = ~apb_master.PREADY;
        if (apb_master.PREADY) begin
          done_s       = 1'b1;
          next_state_s = RESP;
        end else if (cnt_expired_s) begin
          abort_s      = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = ACCESS;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // APB request registers: captured at grant, held stable until the next grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_r   <= '0;
      pwdata_r  <= '0;
      pwrite_r  <= 1'b0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
    end else begin
      if (load_s) begin
        paddr_r  <= {data_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
        pwrite_r <= data_we_i;
        pwdata_r <= data_we_i ? data_wdata_i : '0;
      end else begin
        paddr_r  <= paddr_r;
        pwrite_r <= pwrite_r;
        pwdata_r <= pwdata_r;
      end
      psel_r    <= (next_state_s == SETUP) || (next_state_s == ACCESS);
      penable_r <= (next_state_s == ACCESS);
    end
  end

  // Response registers: one rvalid per transfer, data/err held until the next completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= (next_state_s == RESP);
      if (done_s) begin
        rdata_r <= pwrite_r ? '0 : apb_master.PRDATA;
        err_r   <= apb_master.PSLVERR;
      end else if (abort_s) begin
        rdata_r <= APB_DATA_WIDTH'(ERR_RDATA);
        err_r   <= 1'b1;
      end else begin
        rdata_r <= rdata_r;
        err_r   <= err_r;
      end
    end
  end

  assign data_gnt_o    = gnt_s;
  assign data_rvalid_o = rvalid_r;
  assign data_rdata_o  = rdata_r;
  assign data_err_o    = err_r;

  assign apb_master.PADDR   = paddr_r;
  assign apb_master.PWDATA  = pwdata_r;
  assign apb_master.PWRITE  = pwrite_r;
  assign apb_master.PSEL    = psel_r;
  assign apb_master.PENABLE = penable_r;

endmodule

// File: tb/tb_mem2apb_bridge.sv
// Scoreboard bench for mem2apb_bridge: an APB slave model answers transfers and
// a monitor compares every rvalid against the queue of expected responses.
module tb_mem2apb_bridge;
  import apb_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  APB_BUS #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) apb ();

  mem2apb_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_req_i   (req),
    .data_addr_i  (addr),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_wdata_i (wdata),
    .data_gnt_o   (gnt),
    .data_rvalid_o(rvalid),
    .data_rdata_o (rdata),
    .data_err_o   (err),
    .apb_master   (apb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_rv = 0;
  int cyc = 0;
  exp_t sb_q[$];

  int          slv_waits = 0;
  bit          slv_hang = 1'b0;
  bit          slv_err = 1'b0;
  bit          slv_late = 1'b0;
  logic [31:0] slv_rdata = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // APB slave: PREADY after slv_waits stalled ACCESS cycles, never when hung.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'd0;
    apb.PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      apb.PRDATA = slv_rdata;
      if (apb.PSEL === 1'b1 && apb.PENABLE === 1'b1) begin
        apb.PREADY = !slv_hang && (acc_cnt >= slv_waits);
        apb.PSLVERR = slv_err;
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        apb.PREADY = slv_late;
        apb.PSLVERR = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && rvalid === 1'b1) begin
        n_rv++;
        if (sb_q.size() == 0) begin
          check_val("unexpected_rvalid", {31'd0, rvalid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("rdata", rdata, e.rdata);
          check_val("err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_xfer(input string nm, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input int waits, input bit hang,
                          input bit serr, input logic [31:0] srd, input int exp_lat);
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    exp_t e;
    bit seen;
    bit unstable;
    exp_addr = {a[31:2], 2'b00};
    exp_wd = w ? wd : 32'd0;
    slv_waits = waits;
    slv_hang = hang;
    slv_err = serr;
    slv_rdata = srd;
    if (hang) begin
      e.rdata = ERR_RDATA;
      e.err = 1'b1;
    end else begin
      e.rdata = w ? 32'd0 : srd;
      e.err = serr;
    end
    sb_q.push_back(e);
    @(negedge clk);
    req = 1'b1; addr = a; we = w; wdata = wd; be = 4'b0011;
    #1 check_val({nm, "_gnt"}, {31'd0, gnt}, 32'd1);
    seen = 1'b0;
    unstable = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0; we = !w;
      #2;
      if (k == 1) begin
        check_val({nm, "_setup"}, {30'd0, apb.PSEL, apb.PENABLE}, 32'd2);
        check_val({nm, "_gnt_busy"}, {31'd0, gnt}, 32'd0);
      end
      if (k == 2) begin
        check_val({nm, "_access"}, {30'd0, apb.PSEL, apb.PENABLE}, 32'd3);
        check_val({nm, "_paddr"}, apb.PADDR, exp_addr);
        check_val({nm, "_pwdata"}, apb.PWDATA, exp_wd);
        check_val({nm, "_pwrite"}, {31'd0, apb.PWRITE}, {31'd0, w});
      end
      if (k > 2 && apb.PENABLE === 1'b1 &&
          (apb.PADDR !== exp_addr || apb.PWDATA !== exp_wd || apb.PSEL !== 1'b1))
        unstable = 1'b1;
      if (rvalid === 1'b1) begin
        seen = 1'b1;
        check_val({nm, "_latency"}, k, exp_lat);
        check_val({nm, "_resp_psel"}, {30'd0, apb.PSEL, apb.PENABLE}, 32'd0);
      end
    end
    check_val({nm, "_rvalid_seen"}, {31'd0, seen}, 32'd1);
    check_val({nm, "_stable"}, {31'd0, unstable}, 32'd0);
  endtask

  initial begin
    int gcyc[$];
    int rv0;
    int g1;
    int g2;
    bit found;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_psel", {31'd0, apb.PSEL}, 32'd0);
    check_val("rst_penable", {31'd0, apb.PENABLE}, 32'd0);
    check_val("rst_pwrite", {31'd0, apb.PWRITE}, 32'd0);
    check_val("rst_paddr", apb.PADDR, 32'd0);
    check_val("rst_pwdata", apb.PWDATA, 32'd0);
    check_val("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer("rd0", 32'h1A10_0004, 1'b0, 32'hFFFF_0000, 0, 1'b0, 1'b0, 32'h0000_00A5, 3);
    run_xfer("wr3", 32'h1A10_1002, 1'b1, 32'h1234_5678, 3, 1'b0, 1'b0, 32'hFFFF_FFFF, 6);
    run_xfer("slverr", 32'h1A10_3010, 1'b0, 32'h0, 1, 1'b0, 1'b1, 32'hCAFE_0001, 4);
    run_xfer("tmo", 32'h1A10_4000, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0BAD_0BAD, 6);

    // Late PREADY after the abort must not produce another response.
    rv0 = n_rv;
    slv_hang = 1'b0;
    slv_late = 1'b1;
    repeat (4) @(negedge clk);
    slv_late = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_val("late_pready_rvalids", n_rv - rv0, 32'd0);
    check_val("late_pready_psel", {31'd0, apb.PSEL}, 32'd0);

    // Back-to-back: request held high for three transfers.
    slv_waits = 0; slv_err = 1'b0; slv_rdata = 32'h55AA_0000;
    for (int i = 0; i < 3; i++) sb_q.push_back('{32'h55AA_0000, 1'b0});
    rv0 = n_rv;
    @(negedge clk);
    req = 1'b1; addr = 32'h1A10_2008; we = 1'b0; wdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      #2;
      if (gnt === 1'b1) begin
        gcyc.push_back(cyc);
        check_val("b2b_idle_at_gnt", {31'd0, apb.PSEL}, 32'd0);
      end
      @(negedge clk);
      if (gcyc.size() == 3) req = 1'b0;
    end
    #2;
    g1 = (gcyc.size() >= 3) ? gcyc[1] - gcyc[0] : -1;
    g2 = (gcyc.size() >= 3) ? gcyc[2] - gcyc[1] : -1;
    check_val("b2b_grants", gcyc.size(), 32'd3);
    check_val("b2b_gap1", g1, 32'd4);
    check_val("b2b_gap2", g2, 32'd4);
    check_val("b2b_rvalids", n_rv - rv0, 32'd3);

    // Reset during ACCESS: controls drop without a clock edge, no response follows.
    slv_hang = 1'b1;
    rv0 = n_rv;
    @(negedge clk);
    req = 1'b1; addr = 32'h1A10_5000; we = 1'b1; wdata = 32'hA5A5_5A5A;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      if (apb.PENABLE === 1'b1) found = 1'b1;
    end
    check_val("rst_mid_reached_access", {31'd0, found}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_mid_psel_penable", {30'd0, apb.PSEL, apb.PENABLE}, 32'd0);
    check_val("rst_mid_pwrite", {31'd0, apb.PWRITE}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slv_hang = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    check_val("rst_mid_no_rvalid", n_rv - rv0, 32'd0);
    run_xfer("post_rst", 32'h1A10_6004, 1'b0, 32'h0, 2, 1'b0, 1'b0, 32'h0F0F_1234, 5);

    repeat (4) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
